// File: rtl/mult8x8_pkg.sv
// Shared constants and select encodings for the 8x8 shift-and-add multiplier.
// Both the datapath and the control FSM import this package.
package mult8x8_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned NIB_W  = DATA_W / 2;
    localparam int unsigned PROD_W = 2 * DATA_W;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_LL = 2'b00;
    localparam sel_t SEL_LH = 2'b01;
    localparam sel_t SEL_HL = 2'b10;
    localparam sel_t SEL_HH = 2'b11;

    localparam sel_t SHIFT_0 = 2'b00;
    localparam sel_t SHIFT_4 = 2'b01;
    localparam sel_t SHIFT_8 = 2'b10;

endpackage

// File: rtl/mult8x8_datapath_if.sv
// Control/data bundle between the multiplier FSM (master) and the datapath (slave).
interface mult8x8_datapath_if;
    import mult8x8_pkg::*;

    logic              start;
    logic [DATA_W-1:0] dataa;
    logic [DATA_W-1:0] datab;
    sel_t              input_sel;
    sel_t              shift_sel;
    logic              clk_ena;
    logic              sclr_n;
    logic              done;
    logic [1:0]        count;
    logic [PROD_W-1:0] product;
    logic [PROD_W-1:0] result;
    logic              result_valid;

    modport master (
        output start, dataa, datab, input_sel, shift_sel, clk_ena, sclr_n, done,
        input  count, product, result, result_valid
    );

    modport slave (
        input  start, dataa, datab, input_sel, shift_sel, clk_ena, sclr_n, done,
        output count, product, result, result_valid
    );

endinterface

// File: rtl/mult4x4_shift.sv
// Combinational 4x4 nibble multiply, positioned into a 16-bit accumulator term.
// The unused shift encoding yields a zero contribution.
module mult4x4_shift
    import mult8x8_pkg::*;
(
    input  logic [NIB_W-1:0]  i_a,
    input  logic [NIB_W-1:0]  i_b,
    input  sel_t              i_shift_sel,
    output logic [PROD_W-1:0] o_term
);

    logic [2*NIB_W-1:0] w_pp;
    logic [PROD_W-1:0]  w_pp_ext;

    assign w_pp     = {{NIB_W{1'b0}}, i_a} * {{NIB_W{1'b0}}, i_b};
    assign w_pp_ext = {{(PROD_W - 2 * NIB_W){1'b0}}, w_pp};

    always_comb begin
        o_term = '0;
        case (i_shift_sel)
            SHIFT_0: o_term = w_pp_ext;
            SHIFT_4: o_term = w_pp_ext << 4;
            SHIFT_8: o_term = w_pp_ext << 8;
            default: o_term = '0;
        endcase
    end

endmodule

// File: rtl/mult8x8_datapath.sv
// Shift-and-add datapath: operand capture, nibble-product accumulation,
// step counter for the FSM and a registered final result.
module mult8x8_datapath
    import mult8x8_pkg::*;
#(
    parameter int unsigned DATA_W_P = DATA_W
) (
    input logic               clk,
    input logic               reset_a_n,
    mult8x8_datapath_if.slave bus
);

    logic [DATA_W_P-1:0] r_opa;
    logic [DATA_W_P-1:0] r_opb;
    logic [1:0]          r_count;
    logic [PROD_W-1:0]   r_product;
    logic [PROD_W-1:0]   r_result;
    logic                r_result_valid;

    sel_t              w_input_sel;
    sel_t              w_shift_sel;
    logic [NIB_W-1:0]  w_a_nib;
    logic [NIB_W-1:0]  w_b_nib;
    logic [PROD_W-1:0] w_term;
    logic              w_clear;
    logic              w_accum;
    logic              w_restart;

    // Masking keeps undriven selects from reaching the accumulator while idle.
    assign w_input_sel = bus.input_sel & {2{bus.clk_ena}};
    assign w_shift_sel = bus.shift_sel & {2{bus.clk_ena}};

    assign w_clear   = bus.clk_ena & ~bus.sclr_n;
    assign w_accum   = bus.clk_ena & bus.sclr_n;
    assign w_restart = w_clear & bus.start;

    always_comb begin
        w_a_nib = r_opa[NIB_W-1:0];
        w_b_nib = r_opb[NIB_W-1:0];
        case (w_input_sel)
            SEL_LL: begin
                w_a_nib = r_opa[NIB_W-1:0];
                w_b_nib = r_opb[NIB_W-1:0];
            end
            SEL_LH: begin
                w_a_nib = r_opa[NIB_W-1:0];
                w_b_nib = r_opb[DATA_W_P-1:NIB_W];
            end
            SEL_HL: begin
                w_a_nib = r_opa[DATA_W_P-1:NIB_W];
                w_b_nib = r_opb[NIB_W-1:0];
            end
            default: begin
                w_a_nib = r_opa[DATA_W_P-1:NIB_W];
                w_b_nib = r_opb[DATA_W_P-1:NIB_W];
            end
        endcase
    end

    mult4x4_shift u_mult4x4_shift (
        .i_a         (w_a_nib),
        .i_b         (w_b_nib),
        .i_shift_sel (w_shift_sel),
        .o_term      (w_term)
    );

    always_ff @(posedge clk or negedge reset_a_n) begin
        if (!reset_a_n) begin
            r_opa     <= '0;
            r_opb     <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else if (w_clear) begin
            r_count   <= '0;
            r_product <= '0;
            if (bus.start) begin
                r_opa <= bus.dataa;
                r_opb <= bus.datab;
            end
        end else if (w_accum) begin
            r_count   <= r_count + 2'd1;
            r_product <= r_product + w_term;
        end
    end

    // A restarting clear takes priority over a coincident done.
    always_ff @(posedge clk or negedge reset_a_n) begin
        if (!reset_a_n) begin
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else if (w_restart) begin
            r_result_valid <= 1'b0;
        end else if (bus.done && !r_result_valid) begin
            r_result       <= r_product;
            r_result_valid <= 1'b1;
        end
    end

    assign bus.count        = r_count;
    assign bus.product      = r_product;
    assign bus.result       = r_result;
    assign bus.result_valid = r_result_valid;

endmodule

// File: doc/mult8x8_datapath.md
Name: mult8x8_datapath

Overview:
- Arithmetic datapath for the 8x8 shift-and-add multiplier. It consumes the control FSM outputs: input_sel, shift_sel, clk_ena, sclr_n and done.
- Per step it captures operands, selects a 4x4 nibble product, shifts it and accumulates it into a 16-bit register.
- It owns the 2-bit step counter that is fed back to the FSM as count.
- It holds a registered final result for downstream consumers.

Parameters:
- DATA_W, 8, operand width. Only 8 is supported; the nibble width is fixed at DATA_W/2 = 4.

Ports:
- clk  input  1  system clock, rising edge.
- reset_a_n  input  1  asynchronous active-low reset.
- start  input  1  operation start, shared with the FSM.
- dataa  input  8  multiplicand, sampled on the clear cycle.
- datab  input  8  multiplier, sampled on the clear cycle.
- input_sel  input  2  nibble-pair select from the FSM.
- shift_sel  input  2  partial-product shift select from the FSM.
- clk_ena  input  1  datapath enable from the FSM.
- sclr_n  input  1  synchronous clear, active-low, qualified by clk_ena.
- done  input  1  FSM done flag.
- count  output  2  step counter, fed back to the FSM.
- product  output  16  live accumulator value.
- result  output  16  registered final product.
- result_valid  output  1  result holds a completed product.

Behaviour:
- Reset (reset_a_n=0, asynchronous): opa, opb, count, product, result and result_valid all go to 0.
- Clear cycle (clk_ena=1, sclr_n=0) at the clock edge:
  - product <= 0, count <= 0.
  - If start=1: opa <= dataa, opb <= datab, result_valid <= 0.
- Accumulate cycle (clk_ena=1, sclr_n=1): product <= product + (pp << sh) mod 2^16; count <= count+1, wrapping 3->0.
- Nibble-pair selection (pp is 8 bits):
  - input_sel 00: pp = opa[3:0]*opb[3:0].
  - input_sel 01: pp = opa[3:0]*opb[7:4].
  - input_sel 10: pp = opa[7:4]*opb[3:0].
  - input_sel 11: pp = opa[7:4]*opb[7:4].
- Shift selection: shift_sel 00 -> sh=0, 01 -> sh=4, 10 -> sh=8, 11 -> contribution forced to 0 (illegal encoding).
- Hold (clk_ena=0): all registers hold. sclr_n=0 has no effect without clk_ena.
- X/Z on input_sel or shift_sel while clk_ena=0 must not propagate into registers; mask the select inputs with clk_ena.
- Legal sequence, cycle by cycle from the clear edge:
  - C0: clear.
  - C1: sel 00/00, count 0->1.
  - C2: sel 01/01, count 1->2.
  - C3: sel 10/01, count 2->3.
  - C4: sel 11/10, count 3->0.
  - C5: FSM raises done.
- Result capture: at the first edge where done=1 and result_valid=0, result <= product and result_valid <= 1. The result is then stable until the next clear cycle with start=1.
- Latency: result_valid rises 6 edges after the clear edge.
- Width: the worst case 0xFF*0xFF = 0xFE01 fits in 16 bits, so no overflow occurs in a legal sequence. Illegal sequences wrap modulo 2^16; no error flag is raised.
- Restart mid-operation (FSM err state issuing clear with start=1): acts as a fresh clear. New operands are captured, the counter restarts at 0 and the previous result is invalidated.
- Simultaneous done=1 and clear with start=1 in the same cycle: the clear wins and result_valid goes to 0.
- Reset asserted mid-operation: immediate return to reset values; the next clear starts cleanly.

Decomposition:
- Shared package mult8x8_pkg holds:
  - the SEL_LL/SEL_LH/SEL_HL/SEL_HH input_sel codes;
  - the SHIFT_0/SHIFT_4/SHIFT_8 shift_sel codes;
  - the constants DATA_W=8 and NIB_W=4.
  - The FSM adopts the same package.
- One sub-module is natural: mult4x4_shift. It is a combinational 4x4 multiply plus the shift to 16 bits.
- The counter, operand registers, accumulator and result register stay in the top level.

Test Plan:
- Reset, then dataa=0x12, datab=0x34 through the legal sequence -> product after C1..C4 is 0x0008, 0x0068, 0x00A8, 0x03A8; result=0x03A8 and result_valid=1 after the done edge; count sequence 0,1,2,3,0.
- dataa=0xFF, datab=0xFF -> result=0xFE01, no wrap.
- dataa=0x00, datab=0xA5 -> result=0x0000, result_valid=1; then a new start with 0x0F*0x10 -> result_valid drops on the clear edge and the final result is 0x00F0.
- Clear with start=1 issued after C2 using operands 0x03*0x05 -> accumulator returns to 0, count=0, final result=0x000F.
- reset_a_n pulsed low at C3 -> all outputs are 0 immediately (asynchronously, before the next edge) and stay 0 until the next clear.
- clk_ena=0 with input_sel/shift_sel=X for 5 cycles between operations -> product, count and result are unchanged and no X appears on any output.
